// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer with per-entry saturating direction counters.
// Optional hit/mispredict statistics counters are enabled by defining BTB_STATS_EN.
module branch_target_buffer #(
   parameter int ADDR_W  = 32,
   parameter int ENTRIES = 16,
   parameter int CTR_W   = 2
) (
   input  logic              Clk,
   input  logic              Rst,
   input  logic              lu_valid,
   input  logic [ADDR_W-1:0] lu_pc,
   output logic              pred_hit,
   output logic              pred_taken,
   output logic [ADDR_W-1:0] pred_target,
   input  logic              upd_valid,
   input  logic [ADDR_W-1:0] upd_pc,
   input  logic [ADDR_W-1:0] upd_target,
   input  logic              upd_taken,
   input  logic              upd_is_jump,
   input  logic              upd_mispredict,
   input  logic              inv_all,
   output logic [31:0]       stat_hits,
   output logic [31:0]       stat_mispred
);

   localparam int IDX_W = $clog2(ENTRIES);
   localparam int TAG_W = ADDR_W - IDX_W - 2;
   localparam logic [CTR_W-1:0] CTR_MAX  = {CTR_W{1'b1}};
   localparam logic [CTR_W-1:0] CTR_WEAK = CTR_W'(1) << (CTR_W - 1);

   logic [ENTRIES-1:0] valid_q, valid_d;
   logic [TAG_W-1:0]   tag_q    [ENTRIES];
   logic [TAG_W-1:0]   tag_d    [ENTRIES];
   logic [ADDR_W-1:0]  target_q [ENTRIES];
   logic [ADDR_W-1:0]  target_d [ENTRIES];
   logic [CTR_W-1:0]   ctr_q    [ENTRIES];
   logic [CTR_W-1:0]   ctr_d    [ENTRIES];

   logic [IDX_W-1:0] lu_idx, upd_idx;
   logic [TAG_W-1:0] lu_tag, upd_tag;
   logic             upd_hit;

   assign lu_idx  = lu_pc[IDX_W+1:2];
   assign lu_tag  = lu_pc[ADDR_W-1:IDX_W+2];
   assign upd_idx = upd_pc[IDX_W+1:2];
   assign upd_tag = upd_pc[ADDR_W-1:IDX_W+2];

   // Lookup reads registered state only, so a same-cycle update is never bypassed.
   assign pred_hit    = lu_valid & valid_q[lu_idx] & (tag_q[lu_idx] == lu_tag);
   assign pred_taken  = pred_hit & ctr_q[lu_idx][CTR_W-1];
   assign pred_target = pred_taken ? target_q[lu_idx] : lu_pc + ADDR_W'(4);

   assign upd_hit = valid_q[upd_idx] & (tag_q[upd_idx] == upd_tag);

   always_comb begin
      // NOTE: every next-state array starts as a copy of the current state so no path leaves it unassigned (no latches).
      valid_d  = valid_q;
      tag_d    = tag_q;
      target_d = target_q;
      ctr_d    = ctr_q;
      if (inv_all) begin
         valid_d = '0;
      end else if (upd_valid) begin
         if (upd_hit) begin
            if (upd_is_jump) begin
               ctr_d[upd_idx]    = CTR_MAX;
               target_d[upd_idx] = upd_target;
            end else if (upd_taken) begin
               if (ctr_q[upd_idx] != CTR_MAX) ctr_d[upd_idx] = ctr_q[upd_idx] + CTR_W'(1);
               target_d[upd_idx] = upd_target;
            end else if (ctr_q[upd_idx] != '0) begin
               ctr_d[upd_idx] = ctr_q[upd_idx] - CTR_W'(1);
            end
         end else if (upd_taken | upd_is_jump) begin
            valid_d[upd_idx]  = 1'b1;
            tag_d[upd_idx]    = upd_tag;
            target_d[upd_idx] = upd_target;
            ctr_d[upd_idx]    = upd_is_jump ? CTR_MAX : CTR_WEAK;
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         valid_q <= '0;
         for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= '0;
      end else begin
         valid_q <= valid_d;
         ctr_q   <= ctr_d;
      end
   end

   // NOTE: tag and target storage has no reset; the cleared valid bits make their contents irrelevant.
   always_ff @(posedge Clk) begin
      if (!Rst) begin
         tag_q    <= tag_d;
         target_q <= target_d;
      end
   end

`ifdef BTB_STATS_EN
   logic [31:0] stat_hits_q, stat_hits_d;
   logic [31:0] stat_mispred_q, stat_mispred_d;

   always_comb begin
      stat_hits_d    = stat_hits_q;
      stat_mispred_d = stat_mispred_q;
      if (pred_hit && stat_hits_q != 32'hFFFF_FFFF)
         stat_hits_d = stat_hits_q + 32'd1;
      if (upd_valid && upd_mispredict && stat_mispred_q != 32'hFFFF_FFFF)
         stat_mispred_d = stat_mispred_q + 32'd1;
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         stat_hits_q    <= '0;
         stat_mispred_q <= '0;
      end else begin
         stat_hits_q    <= stat_hits_d;
         stat_mispred_q <= stat_mispred_d;
      end
   end

   assign stat_hits    = stat_hits_q;
   assign stat_mispred = stat_mispred_q;

   logic unused_pc_lsbs;
   assign unused_pc_lsbs = ^{upd_pc[1:0]};
`else
   assign stat_hits    = '0;
   assign stat_mispred = '0;

   logic unused_inputs;
   assign unused_inputs = ^{upd_pc[1:0], upd_mispredict};
`endif

endmodule

// File: tb/tb_branch_target_buffer.sv
// Randomized and directed bench for branch_target_buffer against an array-based model
// of the entry rules; stats expectations follow BTB_STATS_EN.
module tb_branch_target_buffer;

   localparam int ADDR_W  = 32;
   localparam int ENTRIES = 16;
   localparam int CTR_W   = 2;
   localparam int CMAX    = (1 << CTR_W) - 1;

   logic              Clk = 1'b0;
   logic              Rst;
   logic              lu_valid;
   logic [ADDR_W-1:0] lu_pc;
   logic              pred_hit, pred_taken;
   logic [ADDR_W-1:0] pred_target;
   logic              upd_valid;
   logic [ADDR_W-1:0] upd_pc, upd_target;
   logic              upd_taken, upd_is_jump, upd_mispredict, inv_all;
   logic [31:0]       stat_hits, stat_mispred;

   branch_target_buffer #(.ADDR_W(ADDR_W), .ENTRIES(ENTRIES), .CTR_W(CTR_W)) dut (
      .Clk(Clk), .Rst(Rst),
      .lu_valid(lu_valid), .lu_pc(lu_pc),
      .pred_hit(pred_hit), .pred_taken(pred_taken), .pred_target(pred_target),
      .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_target(upd_target),
      .upd_taken(upd_taken), .upd_is_jump(upd_is_jump), .upd_mispredict(upd_mispredict),
      .inv_all(inv_all), .stat_hits(stat_hits), .stat_mispred(stat_mispred)
   );

   always #5 Clk = ~Clk;

   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Reference model: one record per slot, keyed by (pc / 4) mod ENTRIES, tag = pc / (4*ENTRIES).
   bit              m_valid [ENTRIES];
   longint unsigned m_tag   [ENTRIES];
   logic [31:0]     m_tgt   [ENTRIES];
   int              m_ctr   [ENTRIES];
   longint unsigned m_hits, m_misp;

   function automatic int slot(input logic [31:0] pc);
      return int'((pc / 4) % ENTRIES);
   endfunction

   function automatic longint unsigned tag_of(input logic [31:0] pc);
      return longint'(pc) / (4 * ENTRIES);
   endfunction

   task automatic cycle(input logic rst, input logic lv, input logic [31:0] lpc,
                        input logic uv, input logic [31:0] upc, input logic [31:0] utgt,
                        input logic utk, input logic uj, input logic um, input logic inv);
      bit          e_hit, e_tk;
      logic [31:0] e_tgt;
      int          s;
      Rst = rst; lu_valid = lv; lu_pc = lpc;
      upd_valid = uv; upd_pc = upc; upd_target = utgt;
      upd_taken = utk; upd_is_jump = uj; upd_mispredict = um; inv_all = inv;
      s     = slot(lpc);
      e_hit = lv && m_valid[s] && m_tag[s] == tag_of(lpc);
      e_tk  = e_hit && m_ctr[s] >= (1 << (CTR_W - 1));
      e_tgt = e_tk ? m_tgt[s] : lpc + 32'd4;
      @(negedge Clk);
      check("pred_hit", 64'(pred_hit), 64'(e_hit));
      check("pred_taken", 64'(pred_taken), 64'(e_tk));
      check("pred_target", 64'(pred_target), 64'(e_tgt));
`ifdef BTB_STATS_EN
      check("stat_hits", 64'(stat_hits), m_hits);
      check("stat_mispred", 64'(stat_mispred), m_misp);
`else
      check("stat_hits", 64'(stat_hits), 64'd0);
      check("stat_mispred", 64'(stat_mispred), 64'd0);
`endif
      @(posedge Clk);
      if (rst) begin
         for (int i = 0; i < ENTRIES; i++) begin m_valid[i] = 0; m_ctr[i] = 0; end
         m_hits = 0; m_misp = 0;
      end else begin
         if (e_hit && m_hits != 64'hFFFF_FFFF) m_hits++;
         if (uv && um && m_misp != 64'hFFFF_FFFF) m_misp++;
         s = slot(upc);
         if (inv) begin
            for (int i = 0; i < ENTRIES; i++) m_valid[i] = 0;
         end else if (uv) begin
            if (m_valid[s] && m_tag[s] == tag_of(upc)) begin
               if (uj) begin m_ctr[s] = CMAX; m_tgt[s] = utgt; end
               else if (utk) begin m_ctr[s] = (m_ctr[s] < CMAX) ? m_ctr[s] + 1 : CMAX; m_tgt[s] = utgt; end
               else m_ctr[s] = (m_ctr[s] > 0) ? m_ctr[s] - 1 : 0;
            end else if (utk || uj) begin
               m_valid[s] = 1; m_tag[s] = tag_of(upc); m_tgt[s] = utgt;
               m_ctr[s] = uj ? CMAX : (1 << (CTR_W - 1));
            end
         end
      end
      #1;
   endtask

   task automatic look(input logic [31:0] pc);
      cycle(0, 1, pc, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic upd_look(input logic [31:0] lpc, input logic [31:0] upc, input logic [31:0] tgt,
                           input logic tk, input logic j, input logic mis);
      cycle(0, 1, lpc, 1, upc, tgt, tk, j, mis, 0);
   endtask

   initial begin
      logic [31:0] pc_a, pc_b;
      m_hits = 0; m_misp = 0;
      for (int i = 0; i < ENTRIES; i++) begin m_valid[i] = 0; m_ctr[i] = 0; m_tag[i] = 0; m_tgt[i] = 0; end

      // reset, then first lookup misses with fall-through target
      cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      cycle(1, 0, 0, 1, 32'h100, 32'h999, 1, 0, 0, 0);
      look(32'h100);
      look(32'hFFFF_FFFC);

      // allocate and predict, including ignored low PC bits
      upd_look(32'h100, 32'h100, 32'h200, 1, 0, 0);
      look(32'h100);
      look(32'h102);

      // counter walks down to zero and stays, then back up to saturation
      repeat (3) upd_look(32'h100, 32'h100, 32'h2F0, 0, 0, 0);
      look(32'h100);
      repeat (4) upd_look(32'h100, 32'h100, 32'h204, 1, 0, 0);
      look(32'h100);
      upd_look(32'h100, 32'h100, 32'h208, 0, 0, 0);
      look(32'h100);

      // alias on the same slot, then same-cycle lookup/update
      upd_look(32'h140, 32'h140, 32'h500, 1, 0, 0);
      look(32'h100);
      look(32'h140);
      upd_look(32'h140, 32'h140, 32'h500, 0, 0, 0);
      look(32'h140);

      // invalidate beats a same-cycle allocation
      cycle(0, 1, 32'h140, 1, 32'h300, 32'h800, 1, 0, 0, 1);
      look(32'h300);
      look(32'h140);

      // stats sequence: jump allocate, 5 hits, 3 mispredicts
      upd_look(32'h400, 32'h400, 32'h900, 0, 1, 0);
      repeat (5) look(32'h400);
      repeat (3) upd_look(32'h404, 32'h700, 32'h0, 0, 0, 1);
      look(32'h0);

      // randomized traffic over a small tag pool to keep hit rates high
      for (int n = 0; n < 1500; n++) begin
         pc_a = ($urandom_range(0, 3) << 6) | ($urandom_range(0, ENTRIES - 1) << 2) | $urandom_range(0, 3);
         pc_b = ($urandom_range(0, 15) == 0) ? $urandom : (($urandom_range(0, 3) << 6) | ($urandom_range(0, ENTRIES - 1) << 2));
         cycle(($urandom_range(0, 99) == 0), $urandom_range(0, 7) != 0, pc_a,
               $urandom_range(0, 2) != 0, pc_b, $urandom,
               $urandom_range(0, 1), ($urandom_range(0, 5) == 0), $urandom_range(0, 1),
               ($urandom_range(0, 49) == 0));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
